// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encoding, opcodes,
// datapath select encodings and the packed control-strobe bundle.
// Latency: n/a (definitions only).  Backpressure: n/a.
// Optional feature macro used by the importing RTL: ILLEGAL_TRAP_EN.
package mc_pkg;

  // Debug-visible state codes; values are fixed because they leave the block.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True on the cycle an instruction completes and the FSM heads back to FETCH.
  // A store only completes once memory accepts it.
  function automatic logic retires(input state_e s, input logic mem_ready);
    logic r;
    r = 1'b0;
    case (s)
      ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: r = 1'b1;
      ST_MEM_WRITE:                                       r = mem_ready;
      default:                                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: maps the current state (plus memReady for the FETCH
// strobes) to the datapath control bundle. Purely combinational, zero latency.
// Backpressure: memReady gates IRWrite/PCWrite in FETCH only.
// Ports: state_i (current state), mem_ready_i (memory done), ctrl_o (strobes).
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // PC+4 and the instruction latch only commit once the read lands.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      ST_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with retired-instruction counter.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; +1 per memReady=0 cycle.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while memReady is low.
// Ports: clk, rst_n (async, active-low), opcode (IR[31:26]), memReady;
//   datapath strobes/selects, state (debug), instrCount, illegal (TRAP).
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes until reset;
//   otherwise they retire as uncounted NOPs.
module multi_cycle_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        memReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic [31:0] instrCount,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire;
  ctrl_t       ctrl_dec, ctrl;

  mc_output_decode u_output_decode (
    .state_i     (state_q),
    .mem_ready_i (memReady),
    .ctrl_o      (ctrl_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // opcode is only looked at in DECODE and MEM_ADDR, so the IR may change
  // freely in every other state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (memReady) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = ST_TRAP;
`else
          default:      state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR: begin
        // An opcode that stopped being a load/store here abandons the access.
        if (opcode == OP_LW)      state_d = ST_MEM_READ;
        else if (opcode == OP_SW) state_d = ST_MEM_WRITE;
        else                      state_d = ST_FETCH;
      end
      ST_MEM_READ:  if (memReady) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (memReady) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP:
                    state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase
  end

  // The register is written every cycle so it wraps naturally at 2^32.
  assign retire        = retires(state_q, memReady);
  assign instr_count_d = instr_count_q + {31'd0, retire};

  // While reset is asserted the FSM sits in FETCH, whose decode would raise
  // MemRead; mask everything so the datapath stays quiet until release.
  assign ctrl = rst_n ? ctrl_dec : CTRL_IDLE;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal     = ctrl.illegal;
  assign state       = state_q;
  assign instrCount  = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-instruction expected state and
// strobe sequences are queued when stimulus is planned, then popped and
// compared cycle by cycle. Honours ILLEGAL_TRAP_EN the same way as the RTL.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        memReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [31:0] instrCount;
  logic        illegal;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instrCount(instrCount),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   st;
    logic mr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_count = 32'd0;

  function automatic logic [16:0] dut_vec();
    return {illegal, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  // Reference strobe table, written straight from the state descriptions.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr);
    logic ill, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    {ill, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 11'd0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rdst = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: ill = 1'b1;
      default: ;
    endcase
    return {ill, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Plan one instruction: f_stall / m_stall memReady=0 cycles in FETCH and
  // in the memory access state. Updates the expected retire count.
  task automatic plan_instr(input logic [5:0] op, input int f_stall, input int m_stall);
    for (int i = 0; i < f_stall; i++) sb.push_back('{0, 1'b0});
    sb.push_back('{0, 1'b1});
    sb.push_back('{1, rnd_bit()});
    case (op)
      6'h00: begin sb.push_back('{6, rnd_bit()}); sb.push_back('{7, rnd_bit()}); end
      6'h08: begin sb.push_back('{10, rnd_bit()}); sb.push_back('{11, rnd_bit()}); end
      6'h23: begin
        sb.push_back('{2, rnd_bit()});
        for (int i = 0; i < m_stall; i++) sb.push_back('{3, 1'b0});
        sb.push_back('{3, 1'b1});
        sb.push_back('{4, rnd_bit()});
      end
      6'h2B: begin
        sb.push_back('{2, rnd_bit()});
        for (int i = 0; i < m_stall; i++) sb.push_back('{5, 1'b0});
        sb.push_back('{5, 1'b1});
      end
      6'h04: sb.push_back('{8, rnd_bit()});
      6'h02: sb.push_back('{9, rnd_bit()});
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) sb.push_back('{12, rnd_bit()});
`else
        sb.push_back('{0, 1'b0});
`endif
      end
    endcase
    if (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02}) exp_count = exp_count + 32'd1;
  endtask

  // Pop and compare one cycle per entry. The real opcode is only presented
  // in DECODE/MEM_ADDR; every other cycle sees noise on the opcode bus.
  task automatic drain(input string tag, input logic [5:0] op, input bit chk_cnt);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      memReady = e.mr;
      opcode   = (e.st == 1 || e.st == 2) ? op : 6'($urandom_range(0, 63));
      #1;
      chk($sformatf("%s c%0d state", tag, cyc), {28'd0, state}, e.st);
      chk($sformatf("%s c%0d ctrl", tag, cyc), {15'd0, dut_vec()}, {15'd0, exp_ctrl(e.st, e.mr)});
      cyc++;
    end
    if (chk_cnt) begin
      @(posedge clk);
      #1;
      chk({tag, " instrCount"}, instrCount, exp_count);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    memReady = 1'b0;
    opcode   = 6'h00;
    #1;
    chk("reset state", {28'd0, state}, 32'd0);
    chk("reset ctrl", {15'd0, dut_vec()}, 32'd0);
    chk("reset instrCount", instrCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    plan_instr(6'h00, 0, 0); drain("rtype", 6'h00, 1'b1);
    plan_instr(6'h23, 0, 2); drain("lw_stall", 6'h23, 1'b1);
    plan_instr(6'h2B, 0, 1); drain("sw", 6'h2B, 1'b1);
    plan_instr(6'h08, 0, 0); drain("addi", 6'h08, 1'b1);
    plan_instr(6'h04, 0, 0); drain("beq", 6'h04, 1'b1);
    plan_instr(6'h02, 0, 0); drain("j", 6'h02, 1'b1);
    plan_instr(6'h08, 3, 0); drain("addi_fstall", 6'h08, 1'b1);
    plan_instr(6'h23, 1, 0); drain("lw", 6'h23, 1'b1);

    // Reset pulse in the middle of a stalled store.
    sb.push_back('{0, 1'b1});
    sb.push_back('{1, 1'b1});
    sb.push_back('{2, 1'b1});
    sb.push_back('{5, 1'b0});
    sb.push_back('{5, 1'b0});
    drain("sw_abort", 6'h2B, 1'b0);
    chk("pre-reset instrCount", instrCount, 32'd8);
    chk("pre-reset MemWrite", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("async state", {28'd0, state}, 32'd0);
    chk("async instrCount", instrCount, 32'd0);
    chk("async ctrl", {15'd0, dut_vec()}, 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    plan_instr(6'h00, 0, 0); drain("post_reset", 6'h00, 1'b1);

    // Counter wrap: preload through a non-retiring cycle, then retire once.
    @(negedge clk);
    memReady = 1'b0;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.instr_count_q;
    #1;
    chk("preload instrCount", instrCount, 32'hFFFF_FFFF);
    exp_count = 32'hFFFF_FFFF;
    plan_instr(6'h02, 0, 0); drain("wrap", 6'h02, 1'b1);

    // Unknown opcode: trap or uncounted NOP depending on the build.
    plan_instr(6'h3F, 0, 0); drain("illegal", 6'h3F, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
